// File: rtl/dv_resp_pkg.sv
// rtl/dv_resp_pkg.sv - shared types and constants for the control-stream responder
package dv_resp_pkg;

    localparam int RESP_AW = 16;
    localparam int RESP_DW = 32;

    localparam logic [RESP_DW-1:0] OOR_DATA = '1;

    localparam int REG_CTRL   = 0;
    localparam int REG_OFFSET = 1;

    typedef struct packed {
        logic [RESP_AW-1:0] addr;
        logic [RESP_DW-1:0] data;
    } resp_entry_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_PARTIAL,
        FIFO_FULL
    } fifo_state_t;

endpackage

// File: rtl/dv_resp_fifo.sv
// rtl/dv_resp_fifo.sv - synchronous response FIFO with occupancy-derived full/empty
module dv_resp_fifo
    import dv_resp_pkg::*;
#(
    parameter int W  = 48,
    parameter int FD = 4,
    localparam int PW = $clog2(FD)
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   count
);

    logic [W-1:0]  mem [FD];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    fifo_state_t   state;

    always_comb begin
        state = FIFO_PARTIAL;
        if (count == '0)
            state = FIFO_EMPTY;
        else if (count == (PW+1)'(FD))
            state = FIFO_FULL;
    end

    assign full    = (state == FIFO_FULL);
    assign empty   = (state == FIFO_EMPTY);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dv_ctrl_responder.sv
// rtl/dv_ctrl_responder.sv - register-bank responder for the harness control stream
module dv_ctrl_responder
    import dv_resp_pkg::*;
#(
    parameter int SW    = 16,
    parameter int AW    = 16,
    parameter int DW    = 32,
    parameter int NREGS = 8,
    parameter int FD    = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          ctrl_ready,
    input  logic          ctrl_write,
    input  logic [AW-1:0] ctrl_addr,
    input  logic [DW-1:0] ctrl_data,
    input  logic [SW-1:0] sample_data,
    input  logic          trace_wait,
    output logic          dut_cwait,
    output logic          dut_cready,
    output logic [AW-1:0] dut_addr,
    output logic [DW-1:0] dut_data,
    output logic          dut_sready,
    output logic [SW-1:0] dut_sample,
    output logic          dut_active
);

    localparam int IW = $clog2(NREGS);
    localparam int CW = $clog2(FD) + 1;

    logic [DW-1:0]    regs [NREGS];
    logic [IW-1:0]    idx;
    logic             in_range;
    logic             accept;
    logic             reg_wr;
    logic             sen;
    logic             sen_next;
    logic [SW-1:0]    offset;
    logic [DW-1:0]    resp_data;
    logic [AW+DW-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             pop;
    logic             nonempty_next;

    assign idx      = ctrl_addr[IW+1:2];
    assign in_range = (ctrl_addr[1:0] == 2'b00) && ((ctrl_addr >> (IW + 2)) == '0);
    // Backpressure comes only from the registered count, so no input-to-cwait path exists.
    assign accept   = ctrl_ready & ~fifo_full;
    assign reg_wr   = accept & ctrl_write & in_range;

    always_comb begin
        resp_data = {DW{1'b1}};
        if (in_range)
            resp_data = ctrl_write ? ctrl_data : regs[idx];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (reg_wr) begin
            regs[idx] <= ctrl_data;
        end
    end

    assign sen    = regs[REG_CTRL][0];
    assign offset = regs[REG_OFFSET][SW-1:0];

    dv_resp_fifo #(
        .W  (AW + DW),
        .FD (FD)
    ) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (accept),
        .wdata  ({ctrl_addr, resp_data}),
        .pop    (pop),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign pop        = ~fifo_empty & ~trace_wait;
    assign dut_cready = pop;
    assign dut_cwait  = fifo_full;
    assign dut_addr   = fifo_empty ? '0 : head[AW+DW-1:DW];
    assign dut_data   = fifo_empty ? '0 : head[DW-1:0];

    assign nonempty_next = accept | (pop ? (fifo_count > CW'(1)) : ~fifo_empty);
    assign sen_next      = (reg_wr && idx == IW'(REG_CTRL)) ? ctrl_data[0] : sen;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            dut_sready <= 1'b0;
            dut_sample <= '0;
            dut_active <= 1'b0;
        end else begin
            dut_sready <= sen;
            if (sen)
                dut_sample <= sample_data + offset;
            dut_active <= nonempty_next | sen_next;
        end
    end

endmodule

// File: tb/tb_dv_ctrl_responder.sv
// tb/tb_dv_ctrl_responder.sv - scoreboard bench for dv_ctrl_responder
module tb_dv_ctrl_responder;
    import dv_resp_pkg::*;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        ctrl_ready = 1'b0;
    logic        ctrl_write = 1'b0;
    logic [15:0] ctrl_addr = '0;
    logic [31:0] ctrl_data = '0;
    logic [15:0] sample_data = '0;
    logic        trace_wait = 1'b0;
    logic        dut_cwait;
    logic        dut_cready;
    logic [15:0] dut_addr;
    logic [31:0] dut_data;
    logic        dut_sready;
    logic [15:0] dut_sample;
    logic        dut_active;

    int          checks = 0;
    int          failures = 0;
    resp_entry_t exp_q[$];
    logic [31:0] model [8];

    dv_ctrl_responder #(
        .SW(16), .AW(16), .DW(32), .NREGS(8), .FD(4)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .ctrl_ready  (ctrl_ready),
        .ctrl_write  (ctrl_write),
        .ctrl_addr   (ctrl_addr),
        .ctrl_data   (ctrl_data),
        .sample_data (sample_data),
        .trace_wait  (trace_wait),
        .dut_cwait   (dut_cwait),
        .dut_cready  (dut_cready),
        .dut_addr    (dut_addr),
        .dut_data    (dut_data),
        .dut_sready  (dut_sready),
        .dut_sample  (dut_sample),
        .dut_active  (dut_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        resp_entry_t e;
        if (nreset && dut_cready) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("resp_addr", dut_addr, e.addr);
                check("resp_data", dut_data, e.data);
            end
        end
    end

    task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d);
        logic [31:0] exp_data;
        logic        inr;
        int          n;
        inr = (a[1:0] == 2'b00) && (a[15:5] == '0);
        n = 0;
        ctrl_ready = 1'b1;
        ctrl_write = w;
        ctrl_addr  = a;
        ctrl_data  = d;
        @(negedge clk);
        while (dut_cwait && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200)
            check("accept_timeout", 1, 0);
        if (!inr)
            exp_data = OOR_DATA;
        else if (w) begin
            exp_data = d;
            model[a[4:2]] = d;
        end else
            exp_data = model[a[4:2]];
        exp_q.push_back('{addr: a, data: exp_data});
        @(posedge clk);
        #1;
        ctrl_ready = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cwait"},  dut_cwait,  0);
        check({tag, "_cready"}, dut_cready, 0);
        check({tag, "_addr"},   dut_addr,   0);
        check({tag, "_data"},   dut_data,   0);
        check({tag, "_sready"}, dut_sready, 0);
        check({tag, "_sample"}, dut_sample, 0);
        check({tag, "_active"}, dut_active, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            model[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Write then read of the same register, back to back
        issue(1'b1, 16'h0008, 32'h12345678);
        check("wr_latency_cready", dut_cready, 1);
        check("wr_latency_addr", dut_addr, 16'h0008);
        issue(1'b0, 16'h0008, 32'h0);
        drain();

        // Out-of-range read and dropped write
        issue(1'b0, 16'h0100, 32'h0);
        issue(1'b1, 16'h0102, 32'hDEADBEEF);
        issue(1'b0, 16'h0000, 32'h0);
        issue(1'b0, 16'h0006, 32'h0);
        drain();

        for (int i = 0; i < 12; i++) begin
            int r;
            r = $urandom_range(2, 7);
            issue(1'($urandom_range(0, 1)), 16'(r * 4), 32'($urandom));
        end
        drain();

        // Stall: four writes fill the FIFO, the next two wait for the drain
        trace_wait = 1'b1;
        for (int i = 0; i < 4; i++)
            issue(1'b1, 16'(8 + 4 * i), 32'(32'hA0 + i));
        check("full_cwait", dut_cwait, 1);
        check("full_no_cready", dut_cready, 0);
        check("full_active", dut_active, 1);
        fork
            begin
                issue(1'b1, 16'h0018, 32'hA4);
                issue(1'b1, 16'h001C, 32'hA5);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                check("stall_hold_cwait", dut_cwait, 1);
                check("stall_no_accept", exp_q.size(), 4);
                check("stall_head_addr", dut_addr, 16'h0008);
                trace_wait = 1'b0;
            end
        join
        drain();
        issue(1'b0, 16'h0018, 32'h0);
        issue(1'b0, 16'h001C, 32'h0);
        drain();

        // Sample path: offset wraps, sready two cycles after SEN accept
        sample_data = 16'h0002;
        issue(1'b1, 16'h0004, 32'h0000FFFF);
        issue(1'b1, 16'h0000, 32'h00000001);
        check("sen_sready_n1", dut_sready, 0);
        @(posedge clk);
        #1;
        check("sen_sready_n2", dut_sready, 1);
        check("sample_wrap", dut_sample, 16'h0001);
        check("active_sen", dut_active, 1);
        sample_data = 16'h1234;
        @(posedge clk);
        #1;
        check("sample_offset", dut_sample, 16'h1233);
        drain();

        sample_data = 16'h5555;
        issue(1'b1, 16'h0000, 32'h0);
        check("sen_clr_n1", dut_sready, 1);
        @(posedge clk);
        #1;
        check("sen_clr_n2", dut_sready, 0);
        check("sample_hold", dut_sample, 16'h5554);
        drain();

        // Reset with responses queued and SEN set
        trace_wait = 1'b1;
        issue(1'b1, 16'h0000, 32'h1);
        issue(1'b0, 16'h0000, 32'h0);
        issue(1'b0, 16'h0004, 32'h0);
        @(posedge clk);
        #1;
        check("pre_rst_sready", dut_sready, 1);
        check("pre_rst_active", dut_active, 1);
        nreset = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        for (int i = 0; i < 8; i++)
            model[i] = '0;
        @(negedge clk);
        nreset = 1'b1;
        trace_wait = 1'b0;
        @(posedge clk);
        #1;
        issue(1'b0, 16'h0000, 32'h0);
        issue(1'b0, 16'h0004, 32'h0);
        drain();
        check("post_rst_sready", dut_sready, 0);
        check("post_rst_active", dut_active, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
